// File: rtl/lsu_issue_seq_pkg.sv
// Purpose: shared opcode constants, sequencer state enum and memop decode helper.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
// Optional feature macro: LSU_ISSUE_SEQ_MEMOP_FENCE_EN adds the WAIT_RESP state.
package lsu_issue_seq_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        BUBBLE    = 3'd2,
`ifdef LSU_ISSUE_SEQ_MEMOP_FENCE_EN
        WAIT_RESP = 3'd3,
`endif
        DONE      = 3'd4
    } seq_state_e;

    // Only the major opcode decides; the rest of the word is masked off.
    function automatic logic is_memop(input logic [31:0] instr);
        logic [31:0] w_opc;
        w_opc = instr & 32'h0000_007F;
        return (w_opc == {25'd0, OPC_LOAD}) || (w_opc == {25'd0, OPC_STORE});
    endfunction

endpackage

// File: rtl/lsu_issue_seq_prog_mem.sv
// Purpose: DEPTH x 32 program register file, one write port, one async read port.
// Latency: write visible the cycle after the strobe; read is combinational.
// Backpressure: none; the caller gates the write strobe.
// Ports: clk_i/rst_ni clock and async active-low reset (clears every slot),
//        i_we/i_waddr/i_wdat write port, i_raddr/o_rdat read port.
module lsu_issue_seq_prog_mem #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          i_we,
    input  logic [AW-2:0] i_waddr,
    input  logic [31:0]   i_wdat,
    input  logic [AW-2:0] i_raddr,
    output logic [31:0]   o_rdat
);

    logic [31:0] r_mem [DEPTH];

    // Cleared on reset so two harness copies always start from identical contents.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
    end

    assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/lsu_issue_sequencer.sv
// Purpose: issues a stored program in order over valid/ready, throttling after loads/stores.
// Latency: first valid 1 cycle after start; 1 instr/cycle for non-memops; memops leave a gap.
// Backpressure: instr_o/pc hold while instr_ready_i is low; valid never depends on ready.
// Ports: prog_* program load (IDLE/DONE only), start_i/prog_len_i run control,
//        instr_* issue handshake, *_mem_resp_i completions, busy_o/done_o/pc_o/issued_cnt_o status.
// Optional feature macro: LSU_ISSUE_SEQ_MEMOP_FENCE_EN waits for the memory response
// after each memop instead of a fixed one-cycle bubble.
module lsu_issue_sequencer
    import lsu_issue_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          prog_we_i,
    input  logic [AW-2:0] prog_addr_i,
    input  logic [31:0]   prog_data_i,
    input  logic [AW-1:0] prog_len_i,
    input  logic          start_i,
    output logic [31:0]   instr_o,
    output logic          instr_valid_o,
    input  logic          instr_ready_i,
    input  logic          load_mem_resp_i,
    input  logic          store_mem_resp_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [AW-1:0] pc_o,
    output logic [7:0]    issued_cnt_o
);

    seq_state_e    r_state;
    seq_state_e    w_state_nxt;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_len;
    logic [7:0]    r_cnt;
    logic [31:0]   w_rd_dat;
    logic [AW-1:0] w_pc_inc;
    logic          w_idle_like;
    logic          w_hs;
    logic          w_memop;

    assign w_idle_like = (r_state == IDLE) || (r_state == DONE);
    assign w_hs        = (r_state == ISSUE) && instr_ready_i;
    assign w_memop     = is_memop(w_rd_dat);
    assign w_pc_inc    = r_pc + {{(AW-1){1'b0}}, 1'b1};

    // pc < len <= DEPTH whenever the slot is read for issue, so the low bits suffice.
    lsu_issue_seq_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_mem (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_we    (prog_we_i && w_idle_like),
        .i_waddr (prog_addr_i),
        .i_wdat  (prog_data_i),
        .i_raddr (r_pc[AW-2:0]),
        .o_rdat  (w_rd_dat)
    );

`ifdef LSU_ISSUE_SEQ_MEMOP_FENCE_EN
    // Which completion the outstanding memop is waiting for.
    logic r_wait_load;
    logic w_resp_hit;

    assign w_resp_hit = r_wait_load ? load_mem_resp_i : store_mem_resp_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wait_load <= 1'b0;
        end else if (w_hs) begin
            r_wait_load <= ((w_rd_dat & 32'h0000_007F) == {25'd0, OPC_LOAD});
        end
    end
`else
    logic w_unused_resp;
    assign w_unused_resp = load_mem_resp_i ^ store_mem_resp_i;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start_i) begin
                    w_state_nxt = (prog_len_i == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (instr_ready_i) begin
                    if (w_memop) begin
`ifdef LSU_ISSUE_SEQ_MEMOP_FENCE_EN
                        w_state_nxt = WAIT_RESP;
`else
                        w_state_nxt = BUBBLE;
`endif
                    end else if (w_pc_inc == r_len) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            BUBBLE: begin
                w_state_nxt = (r_pc == r_len) ? DONE : ISSUE;
            end
`ifdef LSU_ISSUE_SEQ_MEMOP_FENCE_EN
            WAIT_RESP: begin
                if (w_resp_hit) begin
                    w_state_nxt = (r_pc == r_len) ? DONE : ISSUE;
                end
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_idle_like && start_i) begin
                r_len <= prog_len_i;
                r_pc  <= '0;
                r_cnt <= '0;
            end else if (w_hs) begin
                r_pc <= w_pc_inc;
                if (r_cnt != 8'hFF) begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

    // Outputs come from registered state only; the slot cannot change during ISSUE.
    assign instr_valid_o = (r_state == ISSUE);
    assign instr_o       = instr_valid_o ? w_rd_dat : 32'd0;
    assign busy_o        = !w_idle_like;
    assign done_o        = (r_state == DONE);
    assign pc_o          = r_pc;
    assign issued_cnt_o  = r_cnt;

endmodule

// File: tb/tb_lsu_issue_sequencer.sv
module tb_lsu_issue_sequencer;

    localparam int DEPTH = 4;
    localparam int AW    = 3;

    logic          clk;
    logic          rst_ni;
    logic          prog_we_i;
    logic [AW-2:0] prog_addr_i;
    logic [31:0]   prog_data_i;
    logic [AW-1:0] prog_len_i;
    logic          start_i;
    logic [31:0]   instr_o;
    logic          instr_valid_o;
    logic          instr_ready_i;
    logic          load_mem_resp_i;
    logic          store_mem_resp_i;
    logic          busy_o;
    logic          done_o;
    logic [AW-1:0] pc_o;
    logic [7:0]    issued_cnt_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q [$];
    logic        pend;
    logic [31:0] pend_dat;

    localparam logic [31:0] ADDI0 = 32'h0000_0093;
    localparam logic [31:0] ADDI1 = 32'h0010_0093;
    localparam logic [31:0] ADDI2 = 32'h0020_0093;
    localparam logic [31:0] ADDI3 = 32'h0030_0093;
    localparam logic [31:0] LW0   = 32'h0000_2083;
    localparam logic [31:0] SW1   = 32'h0010_2023;
    localparam logic [31:0] LW2   = 32'h0040_2103;
    localparam logic [31:0] LW3   = 32'h0080_2183;
    localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;

    lsu_issue_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .prog_we_i        (prog_we_i),
        .prog_addr_i      (prog_addr_i),
        .prog_data_i      (prog_data_i),
        .prog_len_i       (prog_len_i),
        .start_i          (start_i),
        .instr_o          (instr_o),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .load_mem_resp_i  (load_mem_resp_i),
        .store_mem_resp_i (store_mem_resp_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .pc_o             (pc_o),
        .issued_cnt_o     (issued_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [AW-2:0] a, input logic [31:0] d);
        prog_we_i   = 1'b1;
        prog_addr_i = a;
        prog_data_i = d;
        tick();
        prog_we_i   = 1'b0;
    endtask

    task automatic start_run(input logic [AW-1:0] len);
        prog_len_i = len;
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
    endtask

    // Monitor: every handshake pops the scoreboard; a stalled beat must hold.
    always @(negedge clk) begin
        if (rst_ni) begin
            if (pend) begin
                chk("hold_vld", {31'd0, instr_valid_o}, 32'd1);
                chk("hold_dat", instr_o, pend_dat);
            end
            if (instr_valid_o && instr_ready_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL hs_extra act=%h exp=none", instr_o);
                end else begin
                    chk("hs_dat", instr_o, exp_q.pop_front());
                end
            end
            pend     = instr_valid_o && !instr_ready_i;
            pend_dat = instr_o;
        end else begin
            pend = 1'b0;
        end
    end

    initial begin
        rst_ni = 1'b0; prog_we_i = 1'b0; prog_addr_i = '0; prog_data_i = '0;
        prog_len_i = '0; start_i = 1'b0; instr_ready_i = 1'b0;
        load_mem_resp_i = 1'b0; store_mem_resp_i = 1'b0;
        pend = 1'b0; pend_dat = '0;
        #2;
        chk("rst_vld",  {31'd0, instr_valid_o}, 32'd0);
        chk("rst_dat",  instr_o, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_pc",   {29'd0, pc_o}, 32'd0);
        chk("rst_cnt",  {24'd0, issued_cnt_o}, 32'd0);
        tick();
        rst_ni = 1'b1;

        // Back-to-back non-memops.
        prog(2'd0, ADDI0); prog(2'd1, ADDI1); prog(2'd2, ADDI2); prog(2'd3, ADDI3);
        instr_ready_i = 1'b1;
        exp_q.push_back(ADDI0); exp_q.push_back(ADDI1);
        exp_q.push_back(ADDI2); exp_q.push_back(ADDI3);
        start_run(3'd4);
        for (int i = 0; i < 4; i++) begin
            chk("alu_vld", {31'd0, instr_valid_o}, 32'd1);
            chk("alu_pc",  {29'd0, pc_o}, i);
            chk("alu_busy", {31'd0, busy_o}, 32'd1);
            tick();
        end
        chk("alu_done", {31'd0, done_o}, 32'd1);
        chk("alu_vld_end", {31'd0, instr_valid_o}, 32'd0);
        chk("alu_cnt", {24'd0, issued_cnt_o}, 32'd4);

        // Backpressure on slot 0.
        instr_ready_i = 1'b0;
        exp_q.push_back(ADDI0); exp_q.push_back(ADDI1);
        start_run(3'd2);
        chk("bp_done_clr", {31'd0, done_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_vld", {31'd0, instr_valid_o}, 32'd1);
            chk("bp_pc",  {29'd0, pc_o}, 32'd0);
            chk("bp_dat", instr_o, ADDI0);
            tick();
        end
        instr_ready_i = 1'b1;
        chk("bp_pc4", {29'd0, pc_o}, 32'd0);
        tick();
        chk("bp_pc5", {29'd0, pc_o}, 32'd1);
        tick();
        chk("bp_done", {31'd0, done_o}, 32'd1);
        chk("bp_cnt", {24'd0, issued_cnt_o}, 32'd2);

`ifdef LSU_ISSUE_SEQ_MEMOP_FENCE_EN
        // Fence: wrong-type and same-cycle responses are ignored.
        prog(2'd0, LW0); prog(2'd1, ADDI1);
        exp_q.push_back(LW0); exp_q.push_back(ADDI1);
        start_run(3'd2);
        chk("fn_vld1", {31'd0, instr_valid_o}, 32'd1);
        load_mem_resp_i = 1'b1;
        tick();
        load_mem_resp_i = 1'b0;
        chk("fn_wait_vld", {31'd0, instr_valid_o}, 32'd0);
        chk("fn_wait_busy", {31'd0, busy_o}, 32'd1);
        store_mem_resp_i = 1'b1;
        tick();
        store_mem_resp_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("fn_hold", {31'd0, instr_valid_o}, 32'd0);
            tick();
        end
        load_mem_resp_i = 1'b1;
        chk("fn_resp_cyc", {31'd0, instr_valid_o}, 32'd0);
        tick();
        load_mem_resp_i = 1'b0;
        chk("fn_next_vld", {31'd0, instr_valid_o}, 32'd1);
        chk("fn_next_pc",  {29'd0, pc_o}, 32'd1);
        tick();
        chk("fn_done", {31'd0, done_o}, 32'd1);
        chk("fn_cnt", {24'd0, issued_cnt_o}, 32'd2);
`else
        // Memops: one bubble after each.
        prog(2'd0, LW0); prog(2'd1, SW1); prog(2'd2, LW2); prog(2'd3, LW3);
        exp_q.push_back(LW0); exp_q.push_back(SW1);
        exp_q.push_back(LW2); exp_q.push_back(LW3);
        start_run(3'd4);
        for (int i = 0; i < 8; i++) begin
            chk("mem_vld", {31'd0, instr_valid_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("mem_busy", {31'd0, busy_o}, 32'd1);
            tick();
        end
        chk("mem_done", {31'd0, done_o}, 32'd1);
        chk("mem_cnt", {24'd0, issued_cnt_o}, 32'd4);
`endif

        // Start and program write while busy are dropped.
        prog(2'd0, ADDI2); prog(2'd1, ADDI3);
        instr_ready_i = 1'b0;
        exp_q.push_back(ADDI2); exp_q.push_back(ADDI3);
        start_run(3'd2);
        prog_we_i = 1'b1; prog_addr_i = 2'd0; prog_data_i = JUNK;
        start_i = 1'b1; prog_len_i = 3'd1;
        tick();
        prog_we_i = 1'b0; start_i = 1'b0;
        chk("ign_dat", instr_o, ADDI2);
        chk("ign_pc", {29'd0, pc_o}, 32'd0);
        instr_ready_i = 1'b1;
        tick();
        chk("ign_pc1", {29'd0, pc_o}, 32'd1);
        tick();
        chk("ign_done", {31'd0, done_o}, 32'd1);
        chk("ign_cnt", {24'd0, issued_cnt_o}, 32'd2);

        // Reset mid-run.
        instr_ready_i = 1'b0;
        start_run(3'd2);
        chk("mr_vld_pre", {31'd0, instr_valid_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("mr_vld",  {31'd0, instr_valid_o}, 32'd0);
        chk("mr_dat",  instr_o, 32'd0);
        chk("mr_busy", {31'd0, busy_o}, 32'd0);
        chk("mr_done", {31'd0, done_o}, 32'd0);
        chk("mr_pc",   {29'd0, pc_o}, 32'd0);
        chk("mr_cnt",  {24'd0, issued_cnt_o}, 32'd0);
        tick();
        rst_ni = 1'b1;
        instr_ready_i = 1'b1;
        exp_q.push_back(32'd0);
        start_run(3'd1);
        chk("mr_slot_vld", {31'd0, instr_valid_o}, 32'd1);
        chk("mr_slot_dat", instr_o, 32'd0);
        tick();
        chk("mr_slot_done", {31'd0, done_o}, 32'd1);

        // Length zero from IDLE.
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        start_run(3'd0);
        chk("z_done", {31'd0, done_o}, 32'd1);
        chk("z_busy", {31'd0, busy_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("z_vld", {31'd0, instr_valid_o}, 32'd0);
            tick();
        end
        chk("z_cnt", {24'd0, issued_cnt_o}, 32'd0);

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_issue_sequencer.md
# lsu_issue_sequencer

Program-driven instruction issuer that feeds the `cva6_processor_shim` instruction port. It holds a short program of 32-bit RISC-V instructions, issues them in order over a valid/ready handshake, and throttles issue after every load or store. It replaces ad-hoc bench feeding logic and gives the two-copy non-interference harness one reusable, identical driver per shim instance.

## Interface

Parameters:
- `DEPTH`, default 4: program slots; power of two, 2..16.
- `AW`, default $clog2(DEPTH)+1: width of pc and length fields; can hold the value DEPTH.

Ports:
- `clk_i`, in, 1: clock. One clock domain.
- `rst_ni`, in, 1: reset. Asynchronous assertion, active-low.
- `prog_we_i`, in, 1: program slot write strobe.
- `prog_addr_i`, in, AW-1: slot index.
- `prog_data_i`, in, 32: instruction to write.
- `prog_len_i`, in, AW: number of instructions to issue, 0..DEPTH. Sampled on start.
- `start_i`, in, 1: begin issuing from slot 0.
- `instr_o`, out, 32: instruction presented to the shim.
- `instr_valid_o`, out, 1: `instr_o` is valid.
- `instr_ready_i`, in, 1: shim `instr_ready_o`.
- `load_mem_resp_i`, in, 1: load completion from the memory side.
- `store_mem_resp_i`, in, 1: store completion from the memory side.
- `busy_o`, out, 1: run in progress.
- `done_o`, out, 1: last run finished; held until the next start.
- `pc_o`, out, AW: index of the next instruction to issue.
- `issued_cnt_o`, out, 8: handshakes completed in the current run; saturates at 255.

## Operation

- The FSM has five states: IDLE, ISSUE, BUBBLE, WAIT_RESP, DONE.
- **IDLE or DONE:**
  - `start_i` latches `prog_len_i` and clears pc and `issued_cnt_o`.
  - If the latched length is 0, go to DONE. Otherwise go to ISSUE.
- **ISSUE:**
  - `instr_valid_o` = 1 and `instr_o` = slot[pc].
  - On `instr_valid_o && instr_ready_i`, increment pc and `issued_cnt_o`.
  - An instruction is a memop when opcode[6:0] is LOAD 7'b0000011 or STORE 7'b0100011.
  - After a memop, go to BUBBLE, or WAIT_RESP when the fence option is compiled in.
  - After a non-memop, stay in ISSUE, or go to DONE if pc reached the length.
- **BUBBLE:** exactly one cycle with `instr_valid_o` = 0. Then go to DONE if pc equals the length, else to ISSUE.
- **WAIT_RESP:** present only with the fence option. Described under Configuration.
- **Program writes:** `prog_we_i` writes slot[`prog_addr_i`] only in IDLE or DONE. Writes in any other state are dropped.
- **Ignored start:** `start_i` in ISSUE, BUBBLE or WAIT_RESP is ignored.
- **Flag outputs:**
  - `busy_o` = 1 in ISSUE, BUBBLE and WAIT_RESP.
  - `done_o` = 1 only in DONE.

## Timing

- Reset values: FSM in IDLE, pc = 0, length = 0, `issued_cnt_o` = 0, `instr_valid_o` = 0, `instr_o` = 0, `busy_o` = 0, `done_o` = 0. All program slots are cleared to 0 so both harness copies start from identical state.
- `instr_valid_o` and `instr_o` are decoded from registered state only. There is no combinational path from `instr_ready_i`.
- Once `instr_valid_o` is raised, `instr_o` stays stable until the handshake.
- Start to first `instr_valid_o`: 1 cycle.
- Back-to-back non-memop issue: 1 instruction per cycle while ready is held.
- Memop issue spacing: the next `instr_valid_o` comes 2 cycles after the handshake. With the fence option it comes 1 cycle after the matching response.
- Reset asserted mid-run: return to IDLE at once. The in-flight instruction is abandoned.
- Handshake on the final instruction: `done_o` rises the next cycle, or after the bubble or response.

## Configuration

- Macro: `LSU_ISSUE_SEQ_MEMOP_FENCE_EN`.
- **Defined:**
  - After a memop handshake, enter WAIT_RESP and hold `instr_valid_o` = 0.
  - Leave WAIT_RESP on `load_mem_resp_i` for a load, or on `store_mem_resp_i` for a store.
  - The opposite response is ignored. A response arriving in the same cycle as the handshake is not counted.
  - Exit WAIT_RESP to DONE if pc equals the length, else to ISSUE.
- **Undefined:**
  - The WAIT_RESP state does not exist and both response inputs are unused.
  - Throttling is the fixed one-cycle BUBBLE.

## Structure

- Shared package `lsu_issue_seq_pkg`:
  - opcode constants `OPC_LOAD` and `OPC_STORE`;
  - FSM state enum `seq_state_e`;
  - helper function `is_memop(logic [31:0])`.
- One sub-module, `lsu_issue_seq_prog_mem`: DEPTH×32 register file with async-reset clear, one write port and one combinational read port.
- The top level contains the FSM, pc, length and counters.

## Test plan

- Non-memops: program 4 ADDI (0x00000093), length 4, start, ready held 1 → valid on cycles 1–4 with slots 0..3 in order, `done_o` on cycle 5, `issued_cnt_o` = 4.
- Memop bubbles, fence option undefined: program LW, SW, LW, LW, ready held 1 → valid pattern 1,0,1,0,1,0,1,0, then `done_o`.
- Backpressure: ready low for 3 cycles while slot 0 is valid → `instr_o` stable, pc = 0 throughout; handshake on cycle 4.
- Fence option defined: LW issued, `store_mem_resp_i` pulsed, then `load_mem_resp_i` 5 cycles later → stays in WAIT_RESP until the load response; next valid 1 cycle after it.
- Boundary cases:
  - length 0 start → `done_o` next cycle, no valid ever;
  - start and `prog_we_i` while busy → ignored.
- Reset mid-run: `rst_ni` low during ISSUE → outputs at reset values immediately, slots read 0.
